// File: rtl/dpd_gain_lut.sv
// dpd_gain_lut: magnitude-indexed complex gain from a ping-pong LUT applied to delayed I/Q.
// Host loads the inactive bank and swaps on a sample boundary; unloaded banks act as unity gain.
module dpd_gain_lut #(
    parameter int DW      = 20,
    parameter int ADDR_W  = 8,
    parameter int GW      = 16,
    parameter int MAG_LAT = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] sig_in_i,
    input  logic signed [DW-1:0] sig_in_q,
    input  logic [DW-1:0]        magn,
    input  logic                 cfg_wr_en,
    input  logic [ADDR_W-1:0]    cfg_wr_addr,
    input  logic signed [GW-1:0] cfg_wr_gain_i,
    input  logic signed [GW-1:0] cfg_wr_gain_q,
    input  logic                 cfg_swap,
    output logic                 cfg_swap_err,
    output logic                 active_bank,
    output logic signed [DW-1:0] sig_out_i,
    output logic signed [DW-1:0] sig_out_q,
    output logic                 out_valid
);
    localparam int DL   = MAG_LAT + 2;
    localparam int PW   = DW + GW;
    localparam int SW   = DW + GW + 1;
    localparam int FRAC = GW - 2;
    localparam int VW   = $clog2(MAG_LAT + 5);
    localparam logic [VW-1:0]        VMAX = VW'(MAG_LAT + 4);
    localparam logic signed [GW-1:0] ONE  = GW'(1 << FRAC);
    localparam logic signed [SW-1:0] RND  = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    logic [2*GW-1:0]        r_mem [2**(ADDR_W+1)];
    logic signed [DW-1:0]   r_di [DL];
    logic signed [DW-1:0]   r_dq [DL];
    logic [ADDR_W-1:0]      r_p1_addr;
    logic                   r_p1_bank, r_p1_byp, r_p2_byp;
    logic [2*GW-1:0]        r_rd;
    logic signed [PW-1:0]   r_pii, r_pqq, r_piq, r_pqi;
    logic signed [DW-1:0]   r_oi, r_oq;
    logic                   r_ab, r_err;
    logic [1:0]             r_loaded;
    logic [VW-1:0]          r_vcnt;
    logic signed [GW-1:0]   w_gi, w_gq;
    logic                   w_swap_ok;
    logic                   w_unused;

    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = (v + RND) >>> FRAC;
        return (s > SMAX) ? SMAX[DW-1:0] : (s < SMIN) ? SMIN[DW-1:0] : s[DW-1:0];
    endfunction

    assign w_gi      = r_p2_byp ? ONE : r_rd[2*GW-1 -: GW];
    assign w_gq      = r_p2_byp ? '0  : r_rd[GW-1:0];
    // a write in the same cycle loads the very bank this swap activates
    assign w_swap_ok = cfg_swap & (r_loaded[~r_ab] | cfg_wr_en);
    assign w_unused  = ^magn[DW-ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (cfg_wr_en) r_mem[{~r_ab, cfg_wr_addr}] <= {cfg_wr_gain_i, cfg_wr_gain_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_di      <= '{default: '0};
            r_dq      <= '{default: '0};
            r_p1_addr <= '0;
            r_p1_bank <= 1'b0;
            r_p1_byp  <= 1'b0;
            r_p2_byp  <= 1'b0;
            r_rd      <= '0;
            r_pii     <= '0;
            r_pqq     <= '0;
            r_piq     <= '0;
            r_pqi     <= '0;
            r_oi      <= '0;
            r_oq      <= '0;
            r_ab      <= 1'b0;
            r_err     <= 1'b0;
            r_loaded  <= '0;
            r_vcnt    <= '0;
        end else begin
            r_di[0] <= sig_in_i;
            r_dq[0] <= sig_in_q;
            for (int k = 1; k < DL; k++) begin
                r_di[k] <= r_di[k-1];
                r_dq[k] <= r_dq[k-1];
            end
            // bank is latched with the address so in-flight samples finish on it
            r_p1_addr <= magn[DW-1 -: ADDR_W];
            r_p1_bank <= r_ab;
            r_p1_byp  <= ~r_loaded[r_ab];
            r_rd      <= r_mem[{r_p1_bank, r_p1_addr}];
            r_p2_byp  <= r_p1_byp;
            r_pii     <= PW'(r_di[DL-1]) * PW'(w_gi);
            r_pqq     <= PW'(r_dq[DL-1]) * PW'(w_gq);
            r_piq     <= PW'(r_di[DL-1]) * PW'(w_gq);
            r_pqi     <= PW'(r_dq[DL-1]) * PW'(w_gi);
            r_oi      <= rnd_sat(SW'(r_pii) - SW'(r_pqq));
            r_oq      <= rnd_sat(SW'(r_piq) + SW'(r_pqi));
            if (cfg_wr_en) r_loaded[~r_ab] <= 1'b1;
            if (w_swap_ok) r_ab <= ~r_ab;
            r_err <= cfg_swap & ~w_swap_ok;
            if (r_vcnt != VMAX) r_vcnt <= r_vcnt + 1'b1;
        end
    end

    assign cfg_swap_err = r_err;
    assign active_bank  = r_ab;
    assign sig_out_i    = r_oi;
    assign sig_out_q    = r_oq;
    assign out_valid    = (r_vcnt == VMAX);
endmodule

// File: tb/tb_dpd_gain_lut.sv
// tb_dpd_gain_lut: directed vectors for bypass, bank load/swap, rotation, saturation and mid-stream swap.
module tb_dpd_gain_lut;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [19:0] sig_in_i = '0, sig_in_q = '0;
    logic [19:0]        magn = '0;
    logic               cfg_wr_en = 1'b0;
    logic [7:0]         cfg_wr_addr = '0;
    logic signed [15:0] cfg_wr_gain_i = '0, cfg_wr_gain_q = '0;
    logic               cfg_swap = 1'b0;
    logic               cfg_swap_err, active_bank, out_valid;
    logic signed [19:0] sig_out_i, sig_out_q;
    int                 n_chk = 0, n_fail = 0;

    dpd_gain_lut dut (
        .clk(clk), .rst_n(rst_n), .sig_in_i(sig_in_i), .sig_in_q(sig_in_q), .magn(magn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_gain_i(cfg_wr_gain_i),
        .cfg_wr_gain_q(cfg_wr_gain_q), .cfg_swap(cfg_swap), .cfg_swap_err(cfg_swap_err),
        .active_bank(active_bank), .sig_out_i(sig_out_i), .sig_out_q(sig_out_q),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int gi, input int gq, input bit sw);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 8'(a);
        cfg_wr_gain_i = 16'(gi);
        cfg_wr_gain_q = 16'(gq);
        cfg_swap = sw;
        tick(1);
        cfg_wr_en = 1'b0;
        cfg_swap = 1'b0;
    endtask

    function automatic int ramp_i(int t); return 1000 * t + 7; endfunction
    function automatic int ramp_q(int t); return -500 * t + 3; endfunction

    // bank0 entry k = (1024k, 2048); bank1 = (8192, 0); samples from 17 on see bank0
    function automatic int ramp_exp(int t, bit want_q);
        longint xi, xq, gi, gq, v;
        xi = ramp_i(t);
        xq = ramp_q(t);
        gi = (t >= 17) ? 1024 * (t % 16) : 8192;
        gq = (t >= 17) ? 2048 : 0;
        v = want_q ? (xi * gq + xq * gi) : (xi * gi - xq * gq);
        return int'((v + 8192) >>> 14);
    endfunction

    initial begin
        sig_in_i = 20'sd100000;
        sig_in_q = 20'sd100000;
        tick(3);
        chk("rst_out_i", sig_out_i, 0);
        chk("rst_out_q", sig_out_q, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bank", active_bank, 0);
        chk("rst_err", cfg_swap_err, 0);
        rst_n = 1'b1;
        tick(17);
        chk("valid_17", out_valid, 0);
        chk("out_i_17", sig_out_i, 0);
        tick(1);
        chk("valid_18", out_valid, 1);
        chk("byp_i", sig_out_i, 100000);
        chk("byp_q", sig_out_q, 100000);

        cfg_swap = 1'b1;
        tick(1);
        cfg_swap = 1'b0;
        chk("swap_unl_err", cfg_swap_err, 1);
        chk("swap_unl_bank", active_bank, 0);
        tick(1);
        chk("swap_err_pulse", cfg_swap_err, 0);

        for (int k = 0; k < 256; k++) wr(k, 8192, 0, 1'b0);
        cfg_swap = 1'b1;
        tick(1);
        cfg_swap = 1'b0;
        chk("swap1_bank", active_bank, 1);
        chk("swap1_err", cfg_swap_err, 0);
        tick(20);
        chk("half_i", sig_out_i, 50000);
        chk("half_q", sig_out_q, 50000);

        cfg_swap = 1'b1;
        tick(1);
        cfg_swap = 1'b0;
        chk("swap_unl0_err", cfg_swap_err, 1);
        chk("swap_unl0_bank", active_bank, 1);

        magn = 20'h5A123;
        sig_in_i = 20'sd123456;
        sig_in_q = -20'sd54321;
        wr(8'h5A, 0, 16384, 1'b1);
        chk("wrswap_bank", active_bank, 0);
        chk("wrswap_err", cfg_swap_err, 0);
        tick(20);
        chk("rot_i", sig_out_i, 54321);
        chk("rot_q", sig_out_q, 123456);

        wr(8'hFF, 32767, 32767, 1'b0);
        cfg_swap = 1'b1;
        tick(1);
        cfg_swap = 1'b0;
        chk("swap2_bank", active_bank, 1);
        magn = 20'hFF000;
        sig_in_i = 20'sd524287;
        sig_in_q = 20'sd524287;
        tick(20);
        chk("satp_i", sig_out_i, 0);
        chk("satp_q", sig_out_q, 524287);
        sig_in_i = -20'sd524288;
        sig_in_q = -20'sd524288;
        tick(20);
        chk("satn_i", sig_out_i, 0);
        chk("satn_q", sig_out_q, -524288);
        magn = 20'h10000;
        sig_in_i = 20'sd3;
        sig_in_q = -20'sd3;
        tick(20);
        chk("rnd_i", sig_out_i, 2);
        chk("rnd_q", sig_out_q, -1);

        for (int k = 0; k < 16; k++) wr(k, 1024 * k, 2048, 1'b0);
        for (int n = 0; n < 60; n++) begin
            if (n >= 18) begin
                chk($sformatf("ramp_i[%0d]", n - 18), sig_out_i, ramp_exp(n - 18, 1'b0));
                chk($sformatf("ramp_q[%0d]", n - 18), sig_out_q, ramp_exp(n - 18, 1'b1));
            end
            sig_in_i = 20'(ramp_i(n));
            sig_in_q = 20'(ramp_q(n));
            magn = (n >= 14) ? 20'(((n - 14) % 16) << 12) : 20'h0;
            cfg_swap = (n == 30);
            tick(1);
        end
        chk("ramp_bank", active_bank, 0);

        sig_in_i = -20'sd77777;
        sig_in_q = 20'sd55555;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_i", sig_out_i, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_bank", active_bank, 0);
        tick(2);
        rst_n = 1'b1;
        tick(17);
        chk("re_valid_17", out_valid, 0);
        tick(1);
        chk("re_valid_18", out_valid, 1);
        chk("re_byp_i", sig_out_i, -77777);
        chk("re_byp_q", sig_out_q, 55555);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
